rs_age: RTL and testbench

RS_AGE -- requirements
Module: rs_age

---
 rtl/sys_defs.sv | 35 +++
 rtl/rs_age_if.sv | 42 ++++
 rtl/rs_age_select.sv | 27 ++
 rtl/rs_age.sv | 182 ++++++++++++++++++
 tb/tb_rs_age.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the reservation-station slice.
//   - FU class encodings (ALU / MULT / MEM)
//   - rs_entry_t: one reservation-station entry (busy, FU class,
//     two source operands with tag + ready bit, opaque payload)
//   - tag_hit(): CDB match helper; tag 0 never matches because it
//     denotes an operand that is permanently ready.
package sys_defs;

    localparam int SYS_TAG_W     = 6;
    localparam int SYS_PAYLOAD_W = 64;
    localparam int SYS_FU_W      = 2;

    typedef enum logic [SYS_FU_W-1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2
    } fu_e;

    typedef struct packed {
        logic                     busy;
        fu_e                      fu;
        logic [SYS_TAG_W-1:0]     t1_tag;
        logic                     t1_rdy;
        logic [SYS_TAG_W-1:0]     t2_tag;
        logic                     t2_rdy;
        logic [SYS_PAYLOAD_W-1:0] payload;
    } rs_entry_t;

    function automatic logic tag_hit(input logic [SYS_TAG_W-1:0] tag,
                                     input logic                 bcast_en,
                                     input logic [SYS_TAG_W-1:0] bcast_tag);
        return bcast_en && (bcast_tag != '0) && (tag == bcast_tag);
    endfunction

endpackage

// File: rtl/rs_age_if.sv
// Dispatch / issue bundle between the rename stage, the reservation
// station and the functional units.
//   master: drives disp_* and fu_ready; sees disp_ready, free_count, issue_*
//   slave : the reservation station (opposite directions)
interface rs_age_if #(
    parameter int RS_DEPTH  = 8,
    parameter int NUM_FU    = 3,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 64
);
    localparam int FU_W  = $clog2(NUM_FU);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic                 disp_valid;
    logic [FU_W-1:0]      disp_fu;
    logic [TAG_W-1:0]     disp_t1_tag;
    logic [TAG_W-1:0]     disp_t2_tag;
    logic                 disp_t1_rdy;
    logic                 disp_t2_rdy;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic                 disp_ready;
    logic [CNT_W-1:0]     free_count;

    logic [NUM_FU-1:0]    fu_ready;
    logic [NUM_FU-1:0]    issue_valid;
    logic [PAYLOAD_W-1:0] issue_payload [NUM_FU];
    logic [IDX_W-1:0]     issue_idx     [NUM_FU];

    modport master (
        output disp_valid, disp_fu, disp_t1_tag, disp_t2_tag,
               disp_t1_rdy, disp_t2_rdy, disp_payload, fu_ready,
        input  disp_ready, free_count, issue_valid, issue_payload, issue_idx
    );

    modport slave (
        input  disp_valid, disp_fu, disp_t1_tag, disp_t2_tag,
               disp_t1_rdy, disp_t2_rdy, disp_payload, fu_ready,
        output disp_ready, free_count, issue_valid, issue_payload, issue_idx
    );

endinterface

// File: rtl/rs_age_select.sv
// Oldest-first picker.
//   elig  : entries that may issue
//   age   : age[i][j] = 1 when entry i is older than entry j
//   grant : one-hot oldest eligible entry, all-zero when none
// Busy entries form a strict total order in the matrix, so at most
// one eligible entry can be older than every other eligible entry.
module rs_age_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] elig,
    input  logic [N-1:0] age [N],
    output logic [N-1:0] grant
);

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = elig[i];
            for (int j = 0; j < N; j++) begin
                if ((j != i) && elig[j] && !age[i][j]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_age.sv
// Age-ordered reservation station.
//   clock, reset     : single clock, synchronous active-high reset
//   squash           : flush every entry at the next edge
//   cdb_en, cdb_tag  : completion broadcast waking up waiting operands
//   bus (slave)      : dispatch in (disp_*), disp_ready / free_count out,
//                      per-FU issue_valid / issue_payload / issue_idx out,
//                      per-FU fu_ready in
// Each FU class issues its oldest eligible entry; an entry frees at the
// edge where its issue is accepted by the unit.
module rs_age
    import sys_defs::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int NUM_FU    = 3,
    parameter int TAG_W     = SYS_TAG_W,
    parameter int PAYLOAD_W = SYS_PAYLOAD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             cdb_en,
    input  logic [TAG_W-1:0] cdb_tag,
    rs_age_if.slave          bus
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t            ent [RS_DEPTH];
    logic [RS_DEPTH-1:0]  age [RS_DEPTH];

    logic [RS_DEPTH-1:0]  busy;
    logic [RS_DEPTH-1:0]  elig;
    logic [RS_DEPTH-1:0]  issue_clr;
    logic [IDX_W-1:0]     free_idx;
    logic [CNT_W-1:0]     free_count;
    logic                 disp_ready;
    logic                 disp_fire;
    logic                 d_t1_rdy;
    logic                 d_t2_rdy;
    logic [SYS_TAG_W-1:0] cdb_tag_s;
    logic [SYS_TAG_W-1:0] d_t1_tag;
    logic [SYS_TAG_W-1:0] d_t2_tag;

    logic [NUM_FU-1:0]    issue_valid;
    logic [NUM_FU-1:0]    issue_fire;
    logic [RS_DEPTH-1:0]  grant_v       [NUM_FU];
    logic [PAYLOAD_W-1:0] issue_payload [NUM_FU];
    logic [IDX_W-1:0]     issue_idx     [NUM_FU];

    assign cdb_tag_s = SYS_TAG_W'(cdb_tag);
    assign d_t1_tag  = SYS_TAG_W'(bus.disp_t1_tag);
    assign d_t2_tag  = SYS_TAG_W'(bus.disp_t2_tag);

    // Status comes from registered busy bits only: a slot freed by an
    // issue this cycle is not offered to dispatch until the next cycle.
    always_comb begin
        busy       = '0;
        elig       = '0;
        free_count = '0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy[i]    = ent[i].busy;
            elig[i]    = ent[i].busy && ent[i].t1_rdy && ent[i].t2_rdy;
            free_count = free_count + CNT_W'(!ent[i].busy);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].busy) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = ~&busy;
    assign disp_fire  = bus.disp_valid && disp_ready && !squash;

    // Operands are captured ready when marked ready, tagged 0, or woken
    // by a broadcast in the very cycle they are written.
    assign d_t1_rdy = bus.disp_t1_rdy || (d_t1_tag == '0) ||
                      tag_hit(d_t1_tag, cdb_en, cdb_tag_s);
    assign d_t2_rdy = bus.disp_t2_rdy || (d_t2_tag == '0) ||
                      tag_hit(d_t2_tag, cdb_en, cdb_tag_s);

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        logic [RS_DEPTH-1:0]  cls_elig;
        logic [RS_DEPTH-1:0]  grant;
        logic [PAYLOAD_W-1:0] pay;
        logic [IDX_W-1:0]     idx;

        always_comb begin
            cls_elig = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                cls_elig[i] = elig[i] &&
                              (SYS_FU_W'(ent[i].fu) == SYS_FU_W'(f));
            end
        end

        rs_age_select #(.N(RS_DEPTH)) u_sel (
            .elig  (cls_elig),
            .age   (age),
            .grant (grant)
        );

        // Grant is one-hot, so OR-reduction acts as the mux and leaves
        // payload/index at zero when nothing issues.
        always_comb begin
            pay = '0;
            idx = '0;
            if (!squash) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (grant[i]) begin
                        pay = pay | PAYLOAD_W'(ent[i].payload);
                        idx = idx | IDX_W'(i);
                    end
                end
            end
        end

        assign issue_valid[f]   = !squash && (|grant);
        assign issue_fire[f]    = issue_valid[f] && bus.fu_ready[f];
        assign grant_v[f]       = grant;
        assign issue_payload[f] = pay;
        assign issue_idx[f]     = idx;
    end

    always_comb begin
        issue_clr = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (issue_fire[f]) begin
                issue_clr = issue_clr | grant_v[f];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent[i].busy   <= 1'b0;
                ent[i].t1_rdy <= 1'b0;
                ent[i].t2_rdy <= 1'b0;
                age[i]        <= '0;
            end
        end else if (squash) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].busy) begin
                    if (tag_hit(ent[i].t1_tag, cdb_en, cdb_tag_s)) ent[i].t1_rdy <= 1'b1;
                    if (tag_hit(ent[i].t2_tag, cdb_en, cdb_tag_s)) ent[i].t2_rdy <= 1'b1;
                end
                if (issue_clr[i]) begin
                    ent[i].busy <= 1'b0;
                end
            end
            // The new entry is the youngest: every other entry becomes
            // older than it (its column set), and it is older than none
            // (its row cleared, overriding the column write on the diagonal).
            if (disp_fire) begin
                ent[free_idx] <= '{busy:    1'b1,
                                   fu:      fu_e'(bus.disp_fu),
                                   t1_tag:  d_t1_tag,
                                   t1_rdy:  d_t1_rdy,
                                   t2_tag:  d_t2_tag,
                                   t2_rdy:  d_t2_rdy,
                                   payload: SYS_PAYLOAD_W'(bus.disp_payload)};
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age[j][free_idx] <= 1'b1;
                end
                age[free_idx] <= '0;
            end
        end
    end

    assign bus.disp_ready    = disp_ready;
    assign bus.free_count    = free_count;
    assign bus.issue_valid   = issue_valid;
    assign bus.issue_payload = issue_payload;
    assign bus.issue_idx     = issue_idx;

endmodule

// File: tb/tb_rs_age.sv
// Scoreboard bench for rs_age: each dispatch that should later issue
// pushes its expected (FU, index, payload); a monitor pops and compares
// on every accepted issue. Cycle-level status checks run inline.
module tb_rs_age;
    import sys_defs::*;

    localparam int DEPTH = 8;
    localparam int NFU   = 3;
    localparam int TW    = 6;
    localparam int PW    = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          squash;
    logic          cdb_en;
    logic [TW-1:0] cdb_tag;

    rs_age_if #(.RS_DEPTH(DEPTH), .NUM_FU(NFU), .TAG_W(TW), .PAYLOAD_W(PW)) bus ();

    rs_age #(.RS_DEPTH(DEPTH), .NUM_FU(NFU), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clock   (clock),
        .reset   (reset),
        .squash  (squash),
        .cdb_en  (cdb_en),
        .cdb_tag (cdb_tag),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          fu;
        int          idx;
        logic [63:0] pay;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic push(int fu, int idx, logic [63:0] pay);
        exp_t e;
        e.fu  = fu;
        e.idx = idx;
        e.pay = pay;
        sb.push_back(e);
    endtask

    // Monitor: every accepted issue must match the oldest pending
    // expectation of its FU class.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            for (int f = 0; f < NFU; f++) begin
                if (bus.issue_valid[f] && bus.fu_ready[f]) begin
                    int k;
                    k = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (k < 0 && sb[i].fu == f) k = i;
                    end
                    if (k < 0) begin
                        n_chk++;
                        $display("FAIL sb_unexpected fu%0d: got issue idx %0d, expected none",
                                 f, bus.issue_idx[f]);
                    end else begin
                        chk($sformatf("sb_idx_fu%0d", f), 64'(bus.issue_idx[f]), 64'(sb[k].idx));
                        chk($sformatf("sb_pay_fu%0d", f), bus.issue_payload[f], sb[k].pay);
                        sb.delete(k);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        cdb_en         = 1'b0;
        cdb_tag        = '0;
        squash         = 1'b0;
    endtask

    task automatic disp(int fu, int t1, bit r1, int t2, bit r2, logic [63:0] pay);
        bus.disp_valid   = 1'b1;
        bus.disp_fu      = 2'(fu);
        bus.disp_t1_tag  = TW'(t1);
        bus.disp_t1_rdy  = r1;
        bus.disp_t2_tag  = TW'(t2);
        bus.disp_t2_rdy  = r2;
        bus.disp_payload = pay;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a concurrent dispatch and squash: reset wins.
        reset = 1'b1;
        idle();
        squash = 1'b1;
        bus.fu_ready = 3'b111;
        disp(0, 0, 1, 0, 1, 64'hDEAD);
        cyc();
        cyc();
        reset = 1'b0;
        idle();
        mid();
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_free_count", 64'(bus.free_count), 64'd8);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        cyc();

        // CDB wakeup: issue one cycle after broadcast, freed the cycle after.
        disp(0, 5, 0, 0, 0, 64'hA1);
        push(0, 0, 64'hA1);
        mid();
        chk("w_c1_iv", 64'(bus.issue_valid), 64'd0);
        chk("w_c1_fc", 64'(bus.free_count), 64'd8);
        cyc();
        idle();
        mid();
        chk("w_c2_iv", 64'(bus.issue_valid[0]), 64'd0);
        chk("w_c2_pay0", bus.issue_payload[0], 64'd0);
        chk("w_c2_fc", 64'(bus.free_count), 64'd7);
        cyc();
        cdb_en = 1'b1;
        cdb_tag = 6'd5;
        mid();
        chk("w_c3_no_bypass", 64'(bus.issue_valid[0]), 64'd0);
        cyc();
        idle();
        mid();
        chk("w_c4_iv", 64'(bus.issue_valid[0]), 64'd1);
        chk("w_c4_idx", 64'(bus.issue_idx[0]), 64'd0);
        chk("w_c4_pay", bus.issue_payload[0], 64'hA1);
        cyc();
        mid();
        chk("w_c5_fc", 64'(bus.free_count), 64'd8);
        chk("w_c5_iv", 64'(bus.issue_valid), 64'd0);
        cyc();

        // Back-pressure: A held while fu_ready[0] is low, then A, then B.
        bus.fu_ready = 3'b110;
        disp(0, 0, 1, 0, 1, 64'hB1);
        push(0, 0, 64'hB1);
        mid();
        cyc();
        disp(0, 0, 1, 0, 1, 64'hB2);
        push(0, 1, 64'hB2);
        mid();
        chk("bp_c2_iv", 64'(bus.issue_valid[0]), 64'd1);
        chk("bp_c2_idx", 64'(bus.issue_idx[0]), 64'd0);
        cyc();
        idle();
        mid();
        chk("bp_c3_idx", 64'(bus.issue_idx[0]), 64'd0);
        chk("bp_c3_pay", bus.issue_payload[0], 64'hB1);
        cyc();
        bus.fu_ready = 3'b111;
        mid();
        chk("bp_c4_idx", 64'(bus.issue_idx[0]), 64'd0);
        cyc();
        mid();
        chk("bp_c5_iv", 64'(bus.issue_valid[0]), 64'd1);
        chk("bp_c5_idx", 64'(bus.issue_idx[0]), 64'd1);
        cyc();
        mid();
        chk("bp_c6_fc", 64'(bus.free_count), 64'd8);
        cyc();

        // Age: a younger ready entry issues-candidate until the older wakes.
        bus.fu_ready = 3'b110;
        disp(0, 7, 0, 0, 1, 64'hD0);
        push(0, 0, 64'hD0);
        mid();
        cyc();
        disp(0, 0, 1, 0, 1, 64'hD1);
        push(0, 1, 64'hD1);
        mid();
        chk("age_c2_iv", 64'(bus.issue_valid[0]), 64'd0);
        cyc();
        idle();
        cdb_en = 1'b1;
        cdb_tag = 6'd7;
        mid();
        chk("age_c3_young", 64'(bus.issue_idx[0]), 64'd1);
        cyc();
        idle();
        bus.fu_ready = 3'b111;
        mid();
        chk("age_c4_old", 64'(bus.issue_idx[0]), 64'd0);
        cyc();
        mid();
        chk("age_c5_young", 64'(bus.issue_idx[0]), 64'd1);
        cyc();
        mid();
        chk("age_c6_fc", 64'(bus.free_count), 64'd8);
        cyc();

        // Dispatch concurrent with matching CDB: eligible next cycle.
        disp(0, 0, 1, 9, 0, 64'hC1);
        cdb_en = 1'b1;
        cdb_tag = 6'd9;
        push(0, 0, 64'hC1);
        mid();
        cyc();
        idle();
        mid();
        chk("cap_iv", 64'(bus.issue_valid[0]), 64'd1);
        chk("cap_idx", 64'(bus.issue_idx[0]), 64'd0);
        cyc();
        // Non-matching broadcast leaves the operand waiting.
        disp(0, 0, 1, 9, 0, 64'hC2);
        cdb_en = 1'b1;
        cdb_tag = 6'd10;
        push(0, 0, 64'hC2);
        mid();
        cyc();
        idle();
        cdb_en = 1'b1;
        cdb_tag = 6'd9;
        mid();
        chk("cap_nomatch_iv", 64'(bus.issue_valid[0]), 64'd0);
        cyc();
        idle();
        mid();
        chk("cap_late_iv", 64'(bus.issue_valid[0]), 64'd1);
        cyc();
        mid();
        chk("cap_fc", 64'(bus.free_count), 64'd8);
        cyc();

        // Three classes issue together.
        bus.fu_ready = 3'b000;
        disp(0, 0, 1, 0, 1, 64'hE0);
        push(0, 0, 64'hE0);
        cyc();
        disp(1, 0, 1, 0, 1, 64'hE1);
        push(1, 1, 64'hE1);
        cyc();
        disp(2, 0, 1, 0, 1, 64'hE2);
        push(2, 2, 64'hE2);
        mid();
        chk("multi_pre_iv", 64'(bus.issue_valid), 64'd3);
        cyc();
        idle();
        bus.fu_ready = 3'b111;
        mid();
        chk("multi_iv", 64'(bus.issue_valid), 64'd7);
        chk("multi_idx1", 64'(bus.issue_idx[1]), 64'd1);
        chk("multi_idx2", 64'(bus.issue_idx[2]), 64'd2);
        cyc();
        mid();
        chk("multi_fc", 64'(bus.free_count), 64'd8);
        cyc();

        // Fill, reject when full, free one, refill the freed index.
        bus.fu_ready = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            disp(2, 0, 1, 0, 1, 64'h300 + 64'(i));
            push(2, i, 64'h300 + 64'(i));
            cyc();
        end
        disp(2, 0, 1, 0, 1, 64'hBAD);
        bus.fu_ready = 3'b100;
        mid();
        chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
        chk("full_fc", 64'(bus.free_count), 64'd0);
        chk("full_idx", 64'(bus.issue_idx[2]), 64'd0);
        cyc();
        disp(2, 0, 1, 0, 1, 64'h399);
        push(2, 0, 64'h399);
        bus.fu_ready = 3'b000;
        mid();
        chk("refill_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("refill_fc", 64'(bus.free_count), 64'd1);
        cyc();
        idle();
        bus.fu_ready = 3'b100;
        mid();
        chk("refull_fc", 64'(bus.free_count), 64'd0);
        chk("refull_oldest", 64'(bus.issue_idx[2]), 64'd1);
        cyc();
        for (int i = 1; i < DEPTH; i++) cyc();
        mid();
        chk("drain_fc", 64'(bus.free_count), 64'd8);
        cyc();

        // Squash with four busy entries and a concurrent dispatch.
        bus.fu_ready = 3'b000;
        for (int i = 0; i < 4; i++) begin
            disp(0, 0, 1, 0, 1, 64'h500 + 64'(i));
            cyc();
        end
        idle();
        mid();
        chk("sq_pre_iv", 64'(bus.issue_valid[0]), 64'd1);
        chk("sq_pre_fc", 64'(bus.free_count), 64'd4);
        cyc();
        disp(0, 0, 1, 0, 1, 64'h5FF);
        squash = 1'b1;
        cdb_en = 1'b1;
        cdb_tag = 6'd3;
        mid();
        chk("sq_iv", 64'(bus.issue_valid), 64'd0);
        chk("sq_pay0", bus.issue_payload[0], 64'd0);
        cyc();
        idle();
        mid();
        chk("sq_post_fc", 64'(bus.free_count), 64'd8);
        chk("sq_post_ready", 64'(bus.disp_ready), 64'd1);
        chk("sq_post_iv", 64'(bus.issue_valid), 64'd0);
        cyc();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
